// File: rtl/axi4_m_r_sched_pkg.sv
// axi4_m_r_sched_pkg
//   Shared types and helpers for the AXI4 read-request scheduler.
//   - state_t : scheduler FSM states
//   - C_4KB   : AXI page size; a burst must not cross this boundary
//   - f_chunk : number of beats in the next burst
`timescale 1ns/1ps
package axi4_m_r_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT
  } state_t;

  localparam int C_4KB = 4096;

  // Next burst length = min(remaining beats, max burst, beats left in the 4KB page).
  // addr_lo is the page offset of a BPB-aligned address, so the page room is always >= 1.
  function automatic logic [8:0] f_chunk(input logic [11:0] addr_lo,
                                         input logic [31:0] rem,
                                         input logic [31:0] bpb,
                                         input logic [31:0] max_beats);
    logic [31:0] room;
    logic [31:0] c;
    room = (32'(C_4KB) - {20'd0, addr_lo}) / bpb;
    c = max_beats;
    if (rem < c) c = rem;
    if (room < c) c = room;
    return 9'(c);
  endfunction

endpackage

// File: rtl/axi4_m_r_sched_rr_arb.sv
// rr_arb
//   Round-robin arbiter. Grants the first requester at or after the internal
//   pointer; on adv the pointer moves to the slot just after the winner.
//   Ports:
//     i_clk, i_rst_n : clock, synchronous active-low reset (pointer -> 0)
//     req            : request vector
//     adv            : accept strobe, advances the pointer past the current winner
//     grant          : one-hot grant (combinational)
//     idx            : index of the granted requester (combinational)
`timescale 1ns/1ps
module rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_reg;
  logic          found;
  int            pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(ptr_reg) + i) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_reg <= '0;
    end else if (adv && found) begin
      ptr_reg <= IW'((int'(idx) + 1) % N);
    end
  end

endmodule

// File: rtl/axi4_m_r_sched.sv
// axi4_m_r_sched
//   Read-request scheduler in front of an AXI4 read-master engine. Arbitrates
//   NREQ requesters round-robin, splits each request into bursts (<= MAX_BEATS,
//   never crossing 4KB), pulses the engine once per burst, watches the R channel
//   for completion and returns per-requester done plus an error flag.
//   Ports:
//     i_clk, i_rst_n                   clock, synchronous active-low reset
//     i_req_valid/addr/beats           requester inputs, slice k = requester k
//     o_req_ready                      1-cycle accept pulse per requester
//     o_done, o_err                    1-cycle completion pulse, error valid with it
//     o_busy                           scheduler not idle
//     o_eng_addr/len/size/valid        burst request to the read engine
//     i_m_rvalid/rready/rlast/rresp    R channel monitor
//     o_tmo                            watchdog pulse
//   Build option: AXI4_M_R_SCHED_TIMEOUT_EN enables a TMO_CYC-cycle watchdog
//   in WAIT; without it o_tmo is tied low and WAIT waits indefinitely.
`timescale 1ns/1ps
module axi4_m_r_sched
  import axi4_m_r_sched_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ADRW      = 32,
  parameter int DATW      = 256,
  parameter int LENW      = 16,
  parameter int MAX_BEATS = 16,
  parameter int TMO_CYC   = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*ADRW-1:0] i_req_addr,
  input  logic [NREQ*LENW-1:0] i_req_beats,
  output logic [NREQ-1:0]   o_req_ready,
  output logic [NREQ-1:0]   o_done,
  output logic              o_err,
  output logic              o_busy,
  output logic [ADRW-1:0]   o_eng_addr,
  output logic [7:0]        o_eng_len,
  output logic [2:0]        o_eng_size,
  output logic              o_eng_valid,
  input  logic              i_m_rvalid,
  input  logic              i_m_rready,
  input  logic              i_m_rlast,
  input  logic [1:0]        i_m_rresp,
  output logic              o_tmo
);

  localparam int BPB  = DATW / 8;
  localparam int SIZE = $clog2(BPB);
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_reg;
  logic [NREQ-1:0]   gnt_oh_reg;
  logic [ADRW-1:0]   addr_reg;
  logic [LENW-1:0]   rem_reg;
  logic [8:0]        chunk_reg;
  logic [8:0]        cnt_reg;
  logic              err_reg;
  logic [NREQ-1:0]   req_ready_reg;
  logic [NREQ-1:0]   done_reg;
  logic              err_out_reg;
  logic [ADRW-1:0]   eng_addr_reg;
  logic [7:0]        eng_len_reg;
  logic              eng_valid_reg;

  logic [NREQ-1:0]   arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              any_req;
  logic              beat;
  logic [ADRW-1:0]   sel_addr;
  logic [LENW-1:0]   sel_beats;
  logic [8:0]        chunk_next;
  logic [8:0]        last_beat;

  assign any_req    = |i_req_valid;
  assign beat       = i_m_rvalid & i_m_rready;
  assign sel_addr   = i_req_addr[int'(arb_idx)*ADRW +: ADRW];
  assign sel_beats  = i_req_beats[int'(arb_idx)*LENW +: LENW];
  assign chunk_next = f_chunk(addr_reg[11:0], 32'(rem_reg), 32'(BPB), 32'(MAX_BEATS));
  assign last_beat  = chunk_reg - 9'd1;

  rr_arb #(.N(NREQ), .IW(IW)) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .req     (i_req_valid),
    .adv     (any_req && (state_reg == S_IDLE)),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

`ifdef AXI4_M_R_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt_reg;
  logic          tmo_reg;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= S_IDLE;
      gnt_oh_reg    <= '0;
      addr_reg      <= '0;
      rem_reg       <= '0;
      chunk_reg     <= '0;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      req_ready_reg <= '0;
      done_reg      <= '0;
      err_out_reg   <= 1'b0;
      eng_addr_reg  <= '0;
      eng_len_reg   <= '0;
      eng_valid_reg <= 1'b0;
`ifdef AXI4_M_R_SCHED_TIMEOUT_EN
      tmo_cnt_reg   <= '0;
      tmo_reg       <= 1'b0;
`endif
    end else begin
      req_ready_reg <= '0;
      done_reg      <= '0;
      err_out_reg   <= 1'b0;
      eng_valid_reg <= 1'b0;
`ifdef AXI4_M_R_SCHED_TIMEOUT_EN
      tmo_reg       <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (any_req) begin
            req_ready_reg <= arb_grant;
            gnt_oh_reg    <= arb_grant;
            addr_reg      <= sel_addr;
            rem_reg       <= sel_beats;
            chunk_reg     <= '0;   // zero-beat requests fall through NEXT unchanged
            err_reg       <= 1'b0;
            state_reg     <= (sel_beats == '0) ? S_NEXT : S_ISSUE;
          end
        end
        S_ISSUE: begin
          chunk_reg     <= chunk_next;
          cnt_reg       <= '0;
          eng_addr_reg  <= addr_reg;
          eng_len_reg   <= 8'(chunk_next - 9'd1);
          eng_valid_reg <= 1'b1;
`ifdef AXI4_M_R_SCHED_TIMEOUT_EN
          tmo_cnt_reg   <= '0;
`endif
          state_reg     <= S_WAIT;
        end
        S_WAIT: begin
          if (beat) begin
            if (i_m_rresp != 2'b00) err_reg <= 1'b1;
            if (i_m_rlast) begin
              // cnt saturates at the expected last index, so anything else is an early RLAST
              if (cnt_reg != last_beat) err_reg <= 1'b1;
              state_reg <= S_NEXT;
            end else if (cnt_reg != last_beat) begin
              cnt_reg <= cnt_reg + 9'd1;
            end
`ifdef AXI4_M_R_SCHED_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
          end
`ifdef AXI4_M_R_SCHED_TIMEOUT_EN
          else if (tmo_cnt_reg == TW'(TMO_CYC - 1)) begin
            // Watchdog: give up on the whole request, remaining chunks are dropped
            tmo_reg     <= 1'b1;
            done_reg    <= gnt_oh_reg;
            err_out_reg <= 1'b1;
            state_reg   <= S_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end
        S_NEXT: begin
          addr_reg <= addr_reg + (ADRW'(chunk_reg) << SIZE);
          rem_reg  <= rem_reg - LENW'(chunk_reg);
          if (rem_reg == LENW'(chunk_reg)) begin
            done_reg    <= gnt_oh_reg;
            err_out_reg <= err_reg;
            state_reg   <= S_IDLE;
          end else begin
            state_reg <= S_ISSUE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = req_ready_reg;
  assign o_done      = done_reg;
  assign o_err       = err_out_reg;
  assign o_busy      = (state_reg != S_IDLE);
  assign o_eng_addr  = eng_addr_reg;
  assign o_eng_len   = eng_len_reg;
  assign o_eng_size  = 3'(SIZE);
  assign o_eng_valid = eng_valid_reg;
`ifdef AXI4_M_R_SCHED_TIMEOUT_EN
  assign o_tmo       = tmo_reg;
`else
  assign o_tmo       = 1'b0;
`endif

endmodule
